// File: rtl/fma_issue_arb.sv
// fma_issue_arb: credit-limited two-requester issue arbiter and response collector for a shared fixed-latency FMA pipeline
module fma_rsp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clr,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic                   valid,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic          do_pop;
  assign valid  = cnt != '0;
  assign do_pop = pop & valid;
  assign dout   = mem[rd];
  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      rd  <= '0;
      wr  <= '0;
      cnt <= '0;
    end else begin
      if (push) mem[wr] <= din;
      wr  <= push ? wr + AW'(1) : wr;
      rd  <= do_pop ? rd + AW'(1) : rd;
      cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

module fma_issue_arb #(
  parameter int FLEN  = 64,
  parameter int LAT   = 4,
  parameter int DEPTH = 4,
  parameter int TAGW  = 4,
  parameter int OPW   = 3*FLEN+6,
  parameter int RESW  = FLEN+5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            Rq0Valid,
  output logic            Rq0Ready,
  input  logic [OPW-1:0]  Rq0Op,
  input  logic [TAGW-1:0] Rq0Tag,
  input  logic            Rq1Valid,
  output logic            Rq1Ready,
  input  logic [OPW-1:0]  Rq1Op,
  input  logic [TAGW-1:0] Rq1Tag,
  input  logic            Flush0,
  output logic            FmaValid,
  output logic [OPW-1:0]  FmaOp,
  input  logic [RESW-1:0] FmaRes,
  output logic            Rsp0Valid,
  input  logic            Rsp0Ready,
  output logic [RESW-1:0] Rsp0Res,
  output logic [TAGW-1:0] Rsp0Tag,
  output logic            Rsp1Valid,
  input  logic            Rsp1Ready,
  output logic [RESW-1:0] Rsp1Res,
  output logic [TAGW-1:0] Rsp1Tag,
  output logic            Busy
);
  localparam int CW = $clog2(DEPTH+LAT+1)+1;
  localparam int FW = $clog2(DEPTH)+1;
  logic [LAT-1:0]       sv, sid;
  logic [TAGW-1:0]      stag [LAT];
  logic [FW-1:0]        cnt0, cnt1;
  logic [CW-1:0]        inf0, inf1;
  logic                 pref, elig0, elig1, v0, v1, g0, g1, issue, push0, push1;
  logic [RESW+TAGW-1:0] r0, r1;
  always_comb begin
    inf0 = '0;
    inf1 = '0;
    for (int i = 0; i < LAT; i++) begin
      inf0 = inf0 + CW'(sv[i] & ~sid[i]);
      inf1 = inf1 + CW'(sv[i] & sid[i]);
    end
  end
  assign elig0 = (inf0 + CW'(cnt0)) < CW'(DEPTH);
  assign elig1 = (inf1 + CW'(cnt1)) < CW'(DEPTH);
  // Flush removes requester 0 from arbitration so requester 1 can still take the slot
  assign v0       = reset_n & Rq0Valid & elig0 & ~Flush0;
  assign v1       = reset_n & Rq1Valid & elig1;
  assign g1       = v1 & (~v0 | pref);
  assign g0       = v0 & ~g1;
  assign issue    = g0 | g1;
  assign Rq0Ready = g0;
  assign Rq1Ready = g1;
  assign FmaValid = issue;
  assign FmaOp    = g0 ? Rq0Op : g1 ? Rq1Op : '0;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sv   <= '0;
      pref <= 1'b0;
    end else begin
      for (int i = LAT-1; i > 0; i--) sv[i] <= sv[i-1] & ~(Flush0 & ~sid[i-1]);
      sv[0] <= issue;
      pref  <= issue ? g0 : pref;
    end
  end
  always_ff @(posedge clk) begin
    for (int i = LAT-1; i > 0; i--) begin
      sid[i]  <= sid[i-1];
      stag[i] <= stag[i-1];
    end
    sid[0]  <= g1;
    stag[0] <= g1 ? Rq1Tag : Rq0Tag;
  end
  assign push0 = sv[LAT-1] & ~sid[LAT-1] & ~Flush0;
  assign push1 = sv[LAT-1] & sid[LAT-1];
  fma_rsp_fifo #(.W(RESW+TAGW), .DEPTH(DEPTH)) u_f0 (
    .clk(clk), .reset_n(reset_n), .clr(Flush0), .push(push0), .din({FmaRes, stag[LAT-1]}),
    .pop(Rsp0Ready), .valid(Rsp0Valid), .dout(r0), .cnt(cnt0)
  );
  fma_rsp_fifo #(.W(RESW+TAGW), .DEPTH(DEPTH)) u_f1 (
    .clk(clk), .reset_n(reset_n), .clr(1'b0), .push(push1), .din({FmaRes, stag[LAT-1]}),
    .pop(Rsp1Ready), .valid(Rsp1Valid), .dout(r1), .cnt(cnt1)
  );
  assign Rsp0Res = r0[TAGW +: RESW];
  assign Rsp0Tag = r0[TAGW-1:0];
  assign Rsp1Res = r1[TAGW +: RESW];
  assign Rsp1Tag = r1[TAGW-1:0];
  assign Busy    = |sv | Rsp0Valid | Rsp1Valid;
endmodule

// File: tb/tb_fma_issue_arb.sv
// tb_fma_issue_arb: directed stimulus with a queue-based reference model checked every cycle
module tb_fma_issue_arb;
  localparam int FLEN = 8, LAT = 4, DEPTH = 4, TAGW = 4, OPW = 3*FLEN+6, RESW = FLEN+5;
  logic clk = 0, reset_n = 0, Flush0 = 0;
  logic Rq0Valid = 0, Rq1Valid = 0, Rsp0Ready = 1, Rsp1Ready = 1;
  logic [OPW-1:0] Rq0Op = '0, Rq1Op = '0, FmaOp;
  logic [TAGW-1:0] Rq0Tag = '0, Rq1Tag = '0, Rsp0Tag, Rsp1Tag;
  logic [RESW-1:0] FmaRes, Rsp0Res, Rsp1Res;
  logic Rq0Ready, Rq1Ready, FmaValid, Rsp0Valid, Rsp1Valid, Busy;
  int errors = 0, checks = 0, cyc = 0, mcyc = 0;

  fma_issue_arb #(.FLEN(FLEN), .LAT(LAT), .DEPTH(DEPTH), .TAGW(TAGW), .OPW(OPW), .RESW(RESW)) dut (
    .clk(clk), .reset_n(reset_n),
    .Rq0Valid(Rq0Valid), .Rq0Ready(Rq0Ready), .Rq0Op(Rq0Op), .Rq0Tag(Rq0Tag),
    .Rq1Valid(Rq1Valid), .Rq1Ready(Rq1Ready), .Rq1Op(Rq1Op), .Rq1Tag(Rq1Tag),
    .Flush0(Flush0), .FmaValid(FmaValid), .FmaOp(FmaOp), .FmaRes(FmaRes),
    .Rsp0Valid(Rsp0Valid), .Rsp0Ready(Rsp0Ready), .Rsp0Res(Rsp0Res), .Rsp0Tag(Rsp0Tag),
    .Rsp1Valid(Rsp1Valid), .Rsp1Ready(Rsp1Ready), .Rsp1Res(Rsp1Res), .Rsp1Tag(Rsp1Tag),
    .Busy(Busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [RESW-1:0] fres(input logic [OPW-1:0] o);
    return o[RESW-1:0] ^ 13'h155;
  endfunction

  // Stand-in FMA: a non-resettable LAT-stage delay line applying fres
  logic [OPW-1:0] fp [LAT];
  always @(posedge clk) begin
    fp[0] <= FmaValid ? FmaOp : '0;
    for (int i = 1; i < LAT; i++) fp[i] <= fp[i-1];
  end
  assign FmaRes = fres(fp[LAT-1]);

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  typedef struct { int due; logic id; logic [TAGW-1:0] tag; logic [OPW-1:0] op; } fl_t;
  typedef struct { logic [TAGW-1:0] tag; logic [RESW-1:0] res; } rs_t;
  fl_t fl[$];
  rs_t q0[$], q1[$];
  logic pref_m = 0;

  task automatic model_step();
    int n0, n1;
    logic g0, g1, v0, v1;
    fl_t tmp[$];
    rs_t r;
    n0 = 0;
    n1 = 0;
    foreach (fl[i]) if (fl[i].id) n1++; else n0++;
    v0 = reset_n && Rq0Valid && !Flush0 && (DEPTH - n0 - int'(q0.size()) > 0);
    v1 = reset_n && Rq1Valid && (DEPTH - n1 - int'(q1.size()) > 0);
    g1 = v1 && (!v0 || pref_m);
    g0 = v0 && !g1;
    chk("rq0_ready", Rq0Ready, g0);
    chk("rq1_ready", Rq1Ready, g1);
    chk("fma_valid", FmaValid, g0 | g1);
    chk("fma_op", FmaOp, g0 ? Rq0Op : g1 ? Rq1Op : OPW'(0));
    chk("rsp0_valid", Rsp0Valid, q0.size() != 0);
    chk("rsp1_valid", Rsp1Valid, q1.size() != 0);
    if (q0.size() != 0) begin
      chk("rsp0_tag", Rsp0Tag, q0[0].tag);
      chk("rsp0_res", Rsp0Res, q0[0].res);
    end
    if (q1.size() != 0) begin
      chk("rsp1_tag", Rsp1Tag, q1[0].tag);
      chk("rsp1_res", Rsp1Res, q1[0].res);
    end
    chk("busy", Busy, fl.size() != 0 || q0.size() != 0 || q1.size() != 0);
    if (!reset_n) begin
      fl.delete();
      q0.delete();
      q1.delete();
      pref_m = 0;
    end else begin
      if (Rsp0Ready && q0.size() != 0) void'(q0.pop_front());
      if (Rsp1Ready && q1.size() != 0) void'(q1.pop_front());
      if (Flush0) begin
        q0.delete();
        foreach (fl[i]) if (fl[i].id) tmp.push_back(fl[i]);
        fl = tmp;
      end
      if (fl.size() != 0 && fl[0].due == mcyc) begin
        r.tag = fl[0].tag;
        r.res = fres(fl[0].op);
        if (fl[0].id) begin
          chk("fifo1_room", q1.size() < DEPTH, 1);
          q1.push_back(r);
        end else begin
          chk("fifo0_room", q0.size() < DEPTH, 1);
          q0.push_back(r);
        end
        void'(fl.pop_front());
      end
      if (g0 || g1) begin
        fl.push_back('{mcyc + LAT, g1, g1 ? Rq1Tag : Rq0Tag, g1 ? Rq1Op : Rq0Op});
        pref_m = g0;
      end
    end
    mcyc++;
  endtask

  always @(negedge clk) if (cyc >= 1) model_step();

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n0, n1;
    Rq0Valid = 1;
    Rq0Op = 30'h55;
    repeat (3) nxt();
    #3;
    chk("reset_rq0_ready", Rq0Ready, 0);
    chk("reset_fma_valid", FmaValid, 0);
    chk("reset_busy", Busy, 0);
    chk("reset_rsp0_valid", Rsp0Valid, 0);
    nxt();
    reset_n = 1;
    Rq0Valid = 0;
    // single op latency
    nxt();
    Rq0Valid = 1;
    Rq0Tag = 3;
    Rq0Op = 30'h1234;
    #3;
    chk("t1_fma_valid", FmaValid, 1);
    chk("t1_fma_op", FmaOp, 30'h1234);
    nxt();
    Rq0Valid = 0;
    repeat (4) begin
      #3 chk("t1_rsp_early", Rsp0Valid, 0);
      nxt();
    end
    #3;
    chk("t1_rsp_valid", Rsp0Valid, 1);
    chk("t1_rsp_tag", Rsp0Tag, 3);
    chk("t1_rsp_res", Rsp0Res, 13'h1361);
    repeat (3) nxt();
    // round-robin with both requesters
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 8; i++) begin
      nxt();
      Rq0Valid = 1;
      Rq1Valid = 1;
      Rq0Tag = TAGW'(i);
      Rq1Tag = TAGW'(i + 8);
      Rq0Op = OPW'(100 + i);
      Rq1Op = OPW'(200 + i);
      #3;
      chk("t2_fma_valid", FmaValid, 1);
      chk("t2_rr", Rq1Ready, (i % 2) == 0);
      n0 += int'(Rq0Ready);
      n1 += int'(Rq1Ready);
    end
    nxt();
    Rq0Valid = 0;
    Rq1Valid = 0;
    chk("t2_issues0", n0, 4);
    chk("t2_issues1", n1, 4);
    repeat (10) nxt();
    // credit exhaustion
    Rsp0Ready = 0;
    n0 = 0;
    for (int i = 0; i < 8; i++) begin
      nxt();
      Rq0Valid = 1;
      Rq0Tag = TAGW'(i);
      Rq0Op = OPW'(300 + i);
      #3 n0 += int'(Rq0Ready);
    end
    chk("t3_issues", n0, 4);
    chk("t3_blocked", Rq0Ready, 0);
    nxt();
    Rsp0Ready = 1;
    #3;
    chk("t3_head_valid", Rsp0Valid, 1);
    n0 = int'(Rq0Ready);
    for (int k = 0; k < 6; k++) begin
      nxt();
      Rsp0Ready = 0;
      Rq0Tag = TAGW'(8 + k);
      Rq0Op = OPW'(400 + k);
      #3 n0 += int'(Rq0Ready);
    end
    chk("t3_one_more", n0, 1);
    nxt();
    Rq0Valid = 0;
    // fill FIFO1, then stream through both full FIFOs
    Rsp1Ready = 0;
    for (int i = 0; i < 8; i++) begin
      nxt();
      Rq1Valid = 1;
      Rq1Tag = TAGW'(i);
      Rq1Op = OPW'(500 + i);
    end
    nxt();
    Rq1Valid = 0;
    repeat (2) nxt();
    for (int i = 0; i < 16; i++) begin
      nxt();
      Rsp0Ready = 1;
      Rsp1Ready = 1;
      Rq0Valid = 1;
      Rq1Valid = 1;
      Rq0Tag = TAGW'(i);
      Rq1Tag = TAGW'(15 - i);
      Rq0Op = OPW'(600 + 3*i);
      Rq1Op = OPW'(700 + 5*i);
      #3;
      if (i == 0) begin
        chk("t4_head0", Rsp0Tag, 1);
        chk("t4_head1", Rsp1Tag, 0);
      end
      if (i == 1) begin
        chk("t4_next0", Rsp0Tag, 2);
        chk("t4_next1", Rsp1Tag, 1);
      end
    end
    nxt();
    Rq0Valid = 0;
    Rq1Valid = 0;
    repeat (12) nxt();
    // flush with buffered and in-flight requester-0 work
    Rsp0Ready = 0;
    for (int i = 1; i <= 2; i++) begin
      nxt();
      Rq0Valid = 1;
      Rq0Tag = TAGW'(i);
      Rq0Op = OPW'(800 + i);
    end
    nxt();
    Rq0Valid = 0;
    repeat (5) nxt();
    for (int i = 3; i <= 4; i++) begin
      nxt();
      Rq0Valid = 1;
      Rq0Tag = TAGW'(i);
      Rq0Op = OPW'(800 + i);
    end
    nxt();
    Flush0 = 1;
    Rq0Tag = 5;
    Rq1Valid = 1;
    Rq1Tag = 9;
    Rq1Op = OPW'(777);
    #3;
    chk("t5_rq0_blocked", Rq0Ready, 0);
    chk("t5_rq1_issue", Rq1Ready, 1);
    n0 = 0;
    for (int k = 1; k <= 5; k++) begin
      nxt();
      Flush0 = 0;
      Rq1Valid = 0;
      Rq0Valid = k <= 4;
      Rq0Tag = TAGW'(10 + k);
      Rq0Op = OPW'(900 + k);
      #3;
      chk("t5_rsp0_gone", Rsp0Valid, 0);
      n0 += int'(Rq0Ready);
      if (k == 5) begin
        chk("t5_rsp1_valid", Rsp1Valid, 1);
        chk("t5_rsp1_tag", Rsp1Tag, 9);
      end
    end
    chk("t5_credit0", n0, 4);
    // reset with work in flight
    nxt();
    Rq1Valid = 1;
    Rq1Tag = 6;
    Rq1Op = OPW'(999);
    nxt();
    Rq1Valid = 0;
    nxt();
    reset_n = 0;
    nxt();
    reset_n = 1;
    #3;
    chk("t6_fma_valid", FmaValid, 0);
    chk("t6_rsp0_valid", Rsp0Valid, 0);
    chk("t6_rsp1_valid", Rsp1Valid, 0);
    chk("t6_busy", Busy, 0);
    repeat (8) begin
      nxt();
      #3;
      chk("t6_stale0", Rsp0Valid, 0);
      chk("t6_stale1", Rsp1Valid, 0);
    end
    nxt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
